// File: rtl/inst_sram_responder.sv
// Instruction-side SRAM-like responder: two-entry in-order queue with fixed response latency.
// Define INST_SRAM_RANDOM_DELAY_EN to add LFSR-driven handshake and response stalls.
module inst_sram_responder #(
  parameter int ADDR_W  = 12,
  parameter int LATENCY = 1
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        inst_sram_req,
  input  logic        inst_sram_wr,
  input  logic [1:0]  inst_sram_size,
  input  logic [3:0]  inst_sram_wstrb,
  input  logic [31:0] inst_sram_addr,
  input  logic [31:0] inst_sram_wdata,
  output logic        inst_sram_addr_ok,
  output logic        inst_sram_data_ok,
  output logic [31:0] inst_sram_rdata
);

  localparam logic [2:0] LAT_C   = 3'(LATENCY);
  // The handshake cycle itself counts as the first cycle of age.
  localparam logic [2:0] NEW_AGE = 3'd1;

  // Slot 0 is always the head; slot 1 is only valid when slot 0 is.
  logic [1:0]        vld_q, vld_d;
  logic [1:0]        wr_q, wr_d;
  logic [ADDR_W-1:0] idx_q [2];
  logic [ADDR_W-1:0] idx_d [2];
  logic [31:0]       wdata_q [2];
  logic [31:0]       wdata_d [2];
  logic [3:0]        wstrb_q [2];
  logic [3:0]        wstrb_d [2];
  logic [2:0]        age_q [2];
  logic [2:0]        age_d [2];

  logic [31:0]       mem [2**ADDR_W];

  logic              stall_a_s;
  logic              stall_d_s;
  logic              push_s;
  logic              pop_s;
  logic              unused_s;

  function automatic logic [2:0] age_inc(input logic [2:0] age);
    age_inc = (age >= LAT_C) ? LAT_C : age + 3'd1;
  endfunction

`ifdef INST_SRAM_RANDOM_DELAY_EN
  logic [15:0] lfsr_q, lfsr_d;

  assign lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      lfsr_q <= 16'hACE1;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  assign stall_a_s = (lfsr_q[1:0] == 2'b11);
  assign stall_d_s = (lfsr_q[3:2] == 2'b11);
`else
  assign stall_a_s = 1'b0;
  assign stall_d_s = 1'b0;
`endif

  assign inst_sram_addr_ok = ~vld_q[1] & ~stall_a_s;
  assign inst_sram_data_ok = vld_q[0] & (age_q[0] == LAT_C) & ~stall_d_s;
  assign inst_sram_rdata   = (inst_sram_data_ok & ~wr_q[0]) ? mem[idx_q[0]] : 32'h0000_0000;

  assign push_s   = inst_sram_req & inst_sram_addr_ok;
  assign pop_s    = inst_sram_data_ok;
  assign unused_s = ^{inst_sram_size, inst_sram_addr[31:ADDR_W+2], inst_sram_addr[1:0]};

  always_comb begin
    vld_d = vld_q;
    wr_d  = wr_q;
    for (int i = 0; i < 2; i++) begin
      idx_d[i]   = idx_q[i];
      wdata_d[i] = wdata_q[i];
      wstrb_d[i] = wstrb_q[i];
      age_d[i]   = vld_q[i] ? age_inc(age_q[i]) : age_q[i];
    end
    if (pop_s) begin
      vld_d      = {1'b0, vld_q[1]};
      wr_d[0]    = wr_q[1];
      idx_d[0]   = idx_q[1];
      wdata_d[0] = wdata_q[1];
      wstrb_d[0] = wstrb_q[1];
      age_d[0]   = age_inc(age_q[1]);
    end else begin
      vld_d = vld_q;
    end
    // New entry lands in the first free slot after any pop has shifted the queue.
    if (push_s) begin
      if (!vld_d[0]) begin
        vld_d[0]   = 1'b1;
        wr_d[0]    = inst_sram_wr;
        idx_d[0]   = inst_sram_addr[ADDR_W+1:2];
        wdata_d[0] = inst_sram_wdata;
        wstrb_d[0] = inst_sram_wstrb;
        age_d[0]   = NEW_AGE;
      end else begin
        vld_d[1]   = 1'b1;
        wr_d[1]    = inst_sram_wr;
        idx_d[1]   = inst_sram_addr[ADDR_W+1:2];
        wdata_d[1] = inst_sram_wdata;
        wstrb_d[1] = inst_sram_wstrb;
        age_d[1]   = NEW_AGE;
      end
    end else begin
      vld_d[1] = vld_d[1];
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      vld_q <= 2'b00;
      wr_q  <= 2'b00;
      for (int i = 0; i < 2; i++) begin
        idx_q[i]   <= '0;
        wdata_q[i] <= 32'h0000_0000;
        wstrb_q[i] <= 4'h0;
        age_q[i]   <= 3'd0;
      end
    end else begin
      vld_q <= vld_d;
      wr_q  <= wr_d;
      for (int i = 0; i < 2; i++) begin
        idx_q[i]   <= idx_d[i];
        wdata_q[i] <= wdata_d[i];
        wstrb_q[i] <= wstrb_d[i];
        age_q[i]   <= age_d[i];
      end
    end
  end

  // Memory contents survive reset; writes commit when their response is issued.
  always_ff @(posedge clk) begin
    if (inst_sram_data_ok && wr_q[0]) begin
      for (int b = 0; b < 4; b++) begin
        if (wstrb_q[0][b]) begin
          mem[idx_q[0]][8*b +: 8] <= wdata_q[0][8*b +: 8];
        end
      end
    end
  end

endmodule

// File: tb/tb_inst_sram_responder.sv
// Randomized self-checking bench: two responders (LATENCY 1 and 3) against a queue-based reference model.
module tb_inst_sram_responder;

  typedef struct {
    logic        wr;
    logic [11:0] idx;
    logic [31:0] wd;
    logic [3:0]  ws;
    int          hs;
  } txn_t;

  logic        clk = 1'b0;
  logic        resetn;
  logic [1:0]  req, wr, aok, dok;
  logic [31:0] addr [2];
  logic [31:0] wdata [2];
  logic [3:0]  wstrb [2];
  logic [31:0] rd0, rd1;

  int          n_checks = 0;
  int          n_errors = 0;
  int          cyc = 0;
  int          lat [2] = '{1, 3};
  int          nhs [2] = '{0, 0};
  int          ndok [2] = '{0, 0};
  logic [31:0] last_rd [2];
  txn_t        mq [2][$];
  int          hs_log [$];
  logic [31:0] mm [2][4096];

  always #5 clk = ~clk;

  inst_sram_responder #(.ADDR_W(12), .LATENCY(1)) u_dut0 (
    .clk(clk), .resetn(resetn), .inst_sram_req(req[0]), .inst_sram_wr(wr[0]),
    .inst_sram_size(2'b10), .inst_sram_wstrb(wstrb[0]), .inst_sram_addr(addr[0]),
    .inst_sram_wdata(wdata[0]), .inst_sram_addr_ok(aok[0]), .inst_sram_data_ok(dok[0]),
    .inst_sram_rdata(rd0));

  inst_sram_responder #(.ADDR_W(12), .LATENCY(3)) u_dut1 (
    .clk(clk), .resetn(resetn), .inst_sram_req(req[1]), .inst_sram_wr(wr[1]),
    .inst_sram_size(2'b10), .inst_sram_wstrb(wstrb[1]), .inst_sram_addr(addr[1]),
    .inst_sram_wdata(wdata[1]), .inst_sram_addr_ok(aok[1]), .inst_sram_data_ok(dok[1]),
    .inst_sram_rdata(rd1));

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  // Reference model step for one responder, evaluated mid-cycle.
  task automatic mon(input int d, input logic rq, input logic w, input logic [31:0] a,
                     input logic [31:0] wd, input logic [3:0] ws, input logic ao,
                     input logic dk, input logic [31:0] rd);
    txn_t        t;
    int          sz;
    logic [31:0] word;
    sz = mq[d].size();
    if (!resetn) begin
      nhs[d] -= sz;
      mq[d].delete();
      check_eq("rst_addr_ok", {31'd0, ao}, 32'd1);
      check_eq("rst_data_ok", {31'd0, dk}, 32'd0);
      check_eq("rst_rdata", rd, 32'd0);
      return;
    end
`ifndef INST_SRAM_RANDOM_DELAY_EN
    check_eq("addr_ok", {31'd0, ao}, {31'd0, sz < 2});
    check_eq("data_ok", {31'd0, dk}, {31'd0, (sz > 0) && (cyc >= mq[d][0].hs + lat[d])});
`else
    if (ao && sz == 2) check_eq("addr_ok_full", {31'd0, ao}, 32'd0);
    if (dk && sz == 0) check_eq("data_ok_empty", {31'd0, dk}, 32'd0);
`endif
    if (dk && sz > 0) begin
      t = mq[d].pop_front();
      ndok[d]++;
      check_eq("latency", {31'd0, cyc >= t.hs + lat[d]}, 32'd1);
      if (t.wr) begin
        check_eq("wr_rdata", rd, 32'd0);
        word = mm[d][t.idx];
        for (int b = 0; b < 4; b++) begin
          if (t.ws[b]) word[8*b +: 8] = t.wd[8*b +: 8];
        end
        mm[d][t.idx] = word;
      end else begin
        check_eq("rd_data", rd, mm[d][t.idx]);
        last_rd[d] = rd;
      end
    end else begin
      check_eq("idle_rdata", rd, 32'd0);
    end
    if (rq && ao) begin
      t.wr = w; t.idx = a[13:2]; t.wd = wd; t.ws = ws; t.hs = cyc;
      mq[d].push_back(t);
      nhs[d]++;
      if (d == 1) hs_log.push_back(cyc);
    end
  endtask

  always @(negedge clk) begin
    cyc++;
    mon(0, req[0], wr[0], addr[0], wdata[0], wstrb[0], aok[0], dok[0], rd0);
    mon(1, req[1], wr[1], addr[1], wdata[1], wstrb[1], aok[1], dok[1], rd1);
  end

  // Raise a request and hold it until the address handshake has happened.
  task automatic issue(input int d, input logic w, input logic [31:0] a,
                       input logic [31:0] wd, input logic [3:0] ws);
    int t = 0;
    req[d] = 1'b1; wr[d] = w; addr[d] = a; wdata[d] = wd; wstrb[d] = ws;
    while (!aok[d] && t < 200) begin
      @(posedge clk); #1;
      t++;
    end
    if (t >= 200) check_eq("handshake_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
    req[d] = 1'b0;
  endtask

  task automatic drain(input int d);
    int t = 0;
    while (mq[d].size() != 0 && t < 500) begin
      @(posedge clk); #1;
      t++;
    end
    if (t >= 500) check_eq("drain_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    resetn = 1'b0;
    req = 2'b00; wr = 2'b00;
    for (int d = 0; d < 2; d++) begin
      addr[d] = 32'd0; wdata[d] = 32'd0; wstrb[d] = 4'h0; last_rd[d] = 32'd0;
    end
    repeat (3) @(posedge clk);
    #1 resetn = 1'b1;

    // Word write then read, byte-merge write, aliased read.
    issue(0, 1'b1, 32'h1C00_0000, 32'h1234_5678, 4'hF);
    issue(0, 1'b0, 32'h1C00_0000, 32'd0, 4'h0);
    drain(0);
    check_eq("word_read", last_rd[0], 32'h1234_5678);
    issue(0, 1'b1, 32'h1C00_0000, 32'h0000_AB00, 4'b0010);
    issue(0, 1'b0, 32'h1C00_0000, 32'd0, 4'h0);
    drain(0);
    check_eq("byte_read", last_rd[0], 32'h1234_AB78);
    last_rd[0] = 32'd0;
    issue(0, 1'b0, 32'h1C00_0000 + (32'd4 << 12), 32'd0, 4'h0);
    drain(0);
    check_eq("alias_read", last_rd[0], 32'h1234_AB78);

    // Preload 256 words into both responders.
    for (int i = 0; i < 256; i++) begin
      issue(0, 1'b1, 32'(i) << 2, $urandom, 4'hF);
      issue(1, 1'b1, 32'(i) << 2, $urandom, 4'hF);
    end
    drain(0);
    drain(1);

    // Queue full with LATENCY 3 and req held high.
    hs_log.delete();
    issue(1, 1'b0, 32'h0, 32'd0, 4'h0);
    issue(1, 1'b0, 32'h4, 32'd0, 4'h0);
    issue(1, 1'b0, 32'h8, 32'd0, 4'h0);
    drain(1);
    check_eq("full_hs_count", 32'(hs_log.size()), 32'd3);
    if (hs_log.size() == 3) begin
      check_eq("full_hs_gap1", 32'(hs_log[1] - hs_log[0]), 32'd1);
`ifndef INST_SRAM_RANDOM_DELAY_EN
      check_eq("full_hs_gap2", 32'(hs_log[2] - hs_log[0]), 32'd4);
`endif
    end

    // Reset with two reads in flight; their responses must never appear.
    issue(1, 1'b0, 32'h10, 32'd0, 4'h0);
    issue(1, 1'b0, 32'h14, 32'd0, 4'h0);
    resetn = 1'b0;
    repeat (3) @(posedge clk);
    #1 resetn = 1'b1;
    check_eq("post_reset_addr_ok", {31'd0, aok[1]}, 32'd1);
    repeat (6) @(posedge clk);
    #1;

    // Random reads on the LATENCY 1 port with aliasing upper address bits.
    for (int i = 0; i < 1000; i++) begin
      if ($urandom_range(3) == 0) begin
        @(posedge clk); #1;
      end
      issue(0, 1'b0, {$urandom_range(32'hFFFF), 2'b00, 8'($urandom_range(255)), 2'b00} | 32'h0,
            32'd0, 4'h0);
    end
    // Random mixed traffic with partial strobes on the LATENCY 3 port.
    for (int i = 0; i < 200; i++) begin
      issue(1, 1'($urandom_range(1)), {20'($urandom), 8'($urandom_range(255)), 2'b00} & 32'h0000_FFFC,
            $urandom, 4'($urandom));
    end
    drain(0);
    drain(1);
    check_eq("resp_count0", 32'(ndok[0]), 32'(nhs[0]));
    check_eq("resp_count1", 32'(ndok[1]), 32'(nhs[1]));

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
